// File: rtl/vga_timing_monitor_if.sv
// VGA pin bundle as seen by the timing monitor.
// The master drives the bus: the display controller or the bench.
// The slave observes it: the monitor.
//   pix_en  pixel strobe, one clk per pixel; the sampling qualifier
//   hSync   horizontal sync, active-high
//   vSync   vertical sync, active-high
//   bright  active-video / draw enable
interface vga_timing_monitor_if;
    logic pix_en;
    logic hSync;
    logic vSync;
    logic bright;

    modport master (output pix_en, hSync, vSync, bright);
    modport slave  (input  pix_en, hSync, vSync, bright);
endinterface

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing checker.
// The block samples the VGA pins once per pixel strobe and rebuilds the pixel and line
// counters. It checks line length, frame length and sync widths against the parameters,
// and it reports lock, single-clk error pulses and a saturating error count.
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   vga            slave side of the VGA pin bundle (pix_en, hSync, vSync, bright)
//   hc_rec/vc_rec  recovered 10-bit pixel / line counters
//   locked         timing verified over LOCK_FRAMES clean frames
//   frame_start    1-clk pulse on a sampled vSync rise
//   err_*          1-clk error pulses (hlen, hsync, vlen, vsync, bright)
//   err_count      total error pulses since reset, saturating at 255
//
// state   | meaning
// SEARCH  | no reference frame yet, or an error was just seen
// ACQUIRE | counting consecutive error-free frames
// LOCKED  | LOCK_FRAMES clean frames seen; counters trustworthy
module vga_timing_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_SYNC      = 96,
    parameter int V_SYNC      = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    vga_timing_monitor_if.slave        vga,
    output logic [9:0]                 hc_rec,
    output logic [9:0]                 vc_rec,
    output logic                       locked,
    output logic                       frame_start,
    output logic                       err_hlen,
    output logic                       err_hsync,
    output logic                       err_vlen,
    output logic                       err_vsync,
    output logic                       err_bright,
    output logic [7:0]                 err_count
);
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
    localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);
    localparam logic [3:0]  LOCK_C    = 4'(LOCK_FRAMES);

    state_t     state, state_nxt;
    logic [3:0] good_frames, good_nxt, good_inc;

    logic       hs_q, vs_q, line_seen, frame_seen;
    logic       hs_q_nxt, vs_q_nxt, line_seen_nxt, frame_seen_nxt;
    logic [9:0] hc_nxt, vc_nxt, hc_sat, vc_sat;
    logic       fs_nxt, hl_nxt, hsy_nxt, vl_nxt, vsy_nxt, br_nxt;
    logic [2:0] n_err;
    logic [8:0] cnt_sum;
    logic       err_any;

    // The comparisons use an 11-bit count+1, so a saturated 1023 cannot wrap to a valid length.
    logic [10:0] hc_inc, vc_inc;
    assign hc_inc = {1'b0, hc_rec} + 11'd1;
    assign vc_inc = {1'b0, vc_rec} + 11'd1;
    assign hc_sat = (hc_rec == 10'h3FF) ? hc_rec : hc_rec + 10'd1;
    assign vc_sat = (vc_rec == 10'h3FF) ? vc_rec : vc_rec + 10'd1;

    always_comb begin
        hc_nxt         = hc_rec;
        vc_nxt         = vc_rec;
        hs_q_nxt       = hs_q;
        vs_q_nxt       = vs_q;
        line_seen_nxt  = line_seen;
        frame_seen_nxt = frame_seen;
        fs_nxt         = 1'b0;
        hl_nxt         = 1'b0;
        hsy_nxt        = 1'b0;
        vl_nxt         = 1'b0;
        vsy_nxt        = 1'b0;
        br_nxt         = 1'b0;
        if (vga.pix_en) begin
            hs_q_nxt = vga.hSync;
            br_nxt   = vga.bright & (vga.hSync | vga.vSync);
            if (vga.hSync && !hs_q) begin
                hc_nxt        = '0;
                line_seen_nxt = 1'b1;
                hl_nxt        = line_seen && (hc_inc != H_TOTAL_C);
                // vs_q holds vSync as it was at the previous line start,
                // so the vertical edges are line-granular.
                vs_q_nxt      = vga.vSync;
                if (vga.vSync && !vs_q) begin
                    vc_nxt         = '0;
                    fs_nxt         = 1'b1;
                    frame_seen_nxt = 1'b1;
                    vl_nxt         = frame_seen && (vc_inc != V_TOTAL_C);
                end else begin
                    vc_nxt  = vc_sat;
                    vsy_nxt = !vga.vSync && vs_q && frame_seen && (vc_inc != V_SYNC_C);
                end
            end else begin
                hc_nxt  = hc_sat;
                hsy_nxt = !vga.hSync && hs_q && line_seen && (hc_inc != H_SYNC_C);
            end
        end
    end

    assign n_err   = 3'(hl_nxt) + 3'(hsy_nxt) + 3'(vl_nxt) + 3'(vsy_nxt) + 3'(br_nxt);
    assign cnt_sum = {1'b0, err_count} + {6'b0, n_err};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_rec      <= '0;
            vc_rec      <= '0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            line_seen   <= 1'b0;
            frame_seen  <= 1'b0;
            frame_start <= 1'b0;
            err_hlen    <= 1'b0;
            err_hsync   <= 1'b0;
            err_vlen    <= 1'b0;
            err_vsync   <= 1'b0;
            err_bright  <= 1'b0;
            err_count   <= '0;
        end else begin
            hc_rec      <= hc_nxt;
            vc_rec      <= vc_nxt;
            hs_q        <= hs_q_nxt;
            vs_q        <= vs_q_nxt;
            line_seen   <= line_seen_nxt;
            frame_seen  <= frame_seen_nxt;
            frame_start <= fs_nxt;
            err_hlen    <= hl_nxt;
            err_hsync   <= hsy_nxt;
            err_vlen    <= vl_nxt;
            err_vsync   <= vsy_nxt;
            err_bright  <= br_nxt;
            err_count   <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        end
    end

    // The FSM reacts to the registered pulses, so locked moves one clk after the pulse.
    assign err_any  = err_hlen | err_hsync | err_vlen | err_vsync | err_bright;
    assign good_inc = good_frames + 4'd1;

    always_comb begin
        state_nxt = state;
        good_nxt  = good_frames;
        if (err_any) begin
            state_nxt = SEARCH;
        end else if (frame_start) begin
            case (state)
                SEARCH: begin
                    state_nxt = ACQUIRE;
                    good_nxt  = '0;
                end
                ACQUIRE: begin
                    good_nxt = good_inc;
                    if (good_inc >= LOCK_C) state_nxt = LOCKED;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            good_frames <= '0;
        end else begin
            state       <= state_nxt;
            good_frames <= good_nxt;
        end
    end

    assign locked = (state == LOCKED);
endmodule

// File: tb/tb_vga_timing_monitor.sv
module tb_vga_timing_monitor;
    localparam int HT = 20;
    localparam int VT = 12;
    localparam int HS = 3;
    localparam int VS = 2;
    localparam int LK = 2;

    logic clk, rst_n;
    logic [9:0] hc_rec, vc_rec;
    logic locked, frame_start, err_hlen, err_hsync, err_vlen, err_vsync, err_bright;
    logic [7:0] err_count;

    vga_timing_monitor_if vbus();

    vga_timing_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HS), .V_SYNC(VS), .LOCK_FRAMES(LK)) dut (
        .clk(clk), .rst_n(rst_n), .vga(vbus),
        .hc_rec(hc_rec), .vc_rec(vc_rec), .locked(locked), .frame_start(frame_start),
        .err_hlen(err_hlen), .err_hsync(err_hsync), .err_vlen(err_vlen), .err_vsync(err_vsync),
        .err_bright(err_bright), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int gap = 3;
    bit cur_hs, cur_vs, cur_br;
    int n_fs, n_hl, n_hsy, n_vl, n_vsy, n_br, n_both;

    // Reference model. It works on whole pixel and line counts and knows nothing of the RTL internals.
    int m_hc, m_vc, m_cnt, m_good, m_state; // m_state: 0 search, 1 acquire, 2 locked
    bit m_hsp, m_vsp, m_lseen, m_fseen;
    bit m_fs, m_hl, m_hsy, m_vl, m_vsy, m_br;

    task automatic model_reset();
        m_hc = 0; m_vc = 0; m_cnt = 0; m_good = 0; m_state = 0;
        m_hsp = 0; m_vsp = 0; m_lseen = 0; m_fseen = 0;
        {m_fs, m_hl, m_hsy, m_vl, m_vsy, m_br} = '0;
    endtask

    task automatic model_step(bit pe, bit hs, bit vs, bit br);
        if (m_hl || m_hsy || m_vl || m_vsy || m_br) m_state = 0;
        else if (m_fs) begin
            if (m_state == 0) begin m_state = 1; m_good = 0; end
            else if (m_state == 1) begin
                m_good++;
                if (m_good >= LK) m_state = 2;
            end
        end
        {m_fs, m_hl, m_hsy, m_vl, m_vsy, m_br} = '0;
        if (pe) begin
            m_br = br && (hs || vs);
            if (hs && !m_hsp) begin
                m_hl = m_lseen && (m_hc + 1 != HT);
                m_lseen = 1; m_hc = 0;
                if (vs && !m_vsp) begin
                    m_vl = m_fseen && (m_vc + 1 != VT);
                    m_fs = 1; m_fseen = 1; m_vc = 0;
                end else begin
                    m_vsy = !vs && m_vsp && m_fseen && (m_vc + 1 != VS);
                    m_vc = (m_vc + 1 > 1023) ? 1023 : m_vc + 1;
                end
                m_vsp = vs;
            end else begin
                m_hsy = !hs && m_hsp && m_lseen && (m_hc + 1 != HS);
                m_hc = (m_hc + 1 > 1023) ? 1023 : m_hc + 1;
            end
            m_hsp = hs;
        end
        m_cnt = m_cnt + m_hl + m_hsy + m_vl + m_vsy + m_br;
        if (m_cnt > 255) m_cnt = 255;
    endtask

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [5:0] dp, mp;
        dp = {frame_start, err_hlen, err_hsync, err_vlen, err_vsync, err_bright};
        mp = {m_fs, m_hl, m_hsy, m_vl, m_vsy, m_br};
        checks++;
        if (hc_rec !== 10'(m_hc) || vc_rec !== 10'(m_vc) || locked !== (m_state == 2) ||
            dp !== mp || err_count !== 8'(m_cnt)) begin
            errors++;
            if (errors < 20)
                $display("FAIL model_cmp t=%0t: hc %0d/%0d vc %0d/%0d locked %0b/%0b pulses %b/%b count %0d/%0d (got/expected)",
                         $time, hc_rec, m_hc, vc_rec, m_vc, locked, (m_state == 2), dp, mp, err_count, m_cnt);
        end
        n_fs += int'(frame_start); n_hl += int'(err_hlen); n_hsy += int'(err_hsync);
        n_vl += int'(err_vlen); n_vsy += int'(err_vsync); n_br += int'(err_bright);
        if (err_bright && err_hlen) n_both++;
    endtask

    task automatic clear_tally();
        n_fs = 0; n_hl = 0; n_hsy = 0; n_vl = 0; n_vsy = 0; n_br = 0; n_both = 0;
    endtask

    task automatic step(bit pe, bit hs, bit vs, bit br);
        vbus.pix_en = pe; vbus.hSync = hs; vbus.vSync = vs; vbus.bright = br;
        cur_hs = hs; cur_vs = vs; cur_br = br;
        @(posedge clk);
        model_step(pe, hs, vs, br);
        @(negedge clk);
        compare_all();
    endtask

    task automatic pix(bit hs, bit vs, bit br);
        int g;
        g = (gap >= 0) ? gap : int'($urandom_range(0, 3));
        repeat (g) step(1'b0, hs, vs, br);
        step(1'b1, hs, vs, br);
    endtask

    // One line of len pixels: hSync high for the first hsw, optional forced bright pixel, optional pause.
    task automatic line(int len, int hsw, bit vs, int br_at, int pause_at, bit active);
        bit hs, br;
        for (int p = 0; p < len; p++) begin
            hs = (p < hsw);
            br = active && (p >= hsw + 2) && (p < len - 2);
            if (p == br_at) br = 1'b1;
            if (p == pause_at) begin
                clear_tally();
                repeat (1000) step(1'b0, cur_hs, cur_vs, cur_br);
                chk("pause_hc_frozen", int'(hc_rec), pause_at - 1);
                chk("pause_locked_kept", int'(locked), 1);
                chk("pause_no_pulses", n_hl + n_hsy + n_vl + n_vsy + n_br + n_fs, 0);
            end
            pix(hs, vs, br);
        end
    endtask

    task automatic frame(int nlines, int vsw, int bad, int blen, int bhsw, int bbr, int pause_at);
        for (int l = 0; l < nlines; l++) begin
            if (l == bad) line(blen, bhsw, l < vsw, bbr, pause_at, l >= 4 && l < nlines - 1);
            else          line(HT, HS, l < vsw, -1, -1, l >= 4 && l < nlines - 1 && l >= vsw);
        end
    endtask

    task automatic good_frame();
        frame(VT, VS, -1, 0, 0, -1, -1);
    endtask

    typedef struct {
        int         len;
        int         hsw;
        int         br_at;
        logic [4:0] exp_mask;   // {bright, vsync, vlen, hsync, hlen}
        int         exp_cnt;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        logic [4:0] mask;
        vecs[0] = '{HT,     HS,     -1, 5'b00000, 0};
        vecs[1] = '{HT + 1, HS,     -1, 5'b00001, 1};
        vecs[2] = '{HT - 1, HS,     -1, 5'b00001, 1};
        vecs[3] = '{HT,     HS - 1, -1, 5'b00010, 1};
        vecs[4] = '{HT,     HS + 1, -1, 5'b00010, 1};
        vecs[5] = '{HT + 2, HS + 2, -1, 5'b00011, 2};
        vecs[6] = '{HT,     HS,      1, 5'b10000, 1};
        vecs[7] = '{HT,     HS,     10, 5'b00000, 0};
        vecs[8] = '{HT + 1, HS - 1,  0, 5'b10011, 3};

        rst_n = 1'b0;
        vbus.pix_en = 0; vbus.hSync = 0; vbus.vSync = 0; vbus.bright = 0;
        clear_tally();
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_hc", int'(hc_rec), 0);
        chk("reset_vc", int'(vc_rec), 0);
        chk("reset_count", int'(err_count), 0);
        chk("reset_flags", int'({locked, frame_start, err_hlen, err_hsync, err_vlen, err_vsync, err_bright}), 0);
        rst_n = 1'b1;

        // Nominal stream: the first rise enters ACQUIRE, and the third rise locks.
        good_frame(); good_frame();
        chk("nominal_unlocked_after_2", int'(locked), 0);
        good_frame();
        chk("nominal_locked_after_3", int'(locked), 1);
        good_frame(); good_frame();
        chk("nominal_no_errors", int'(err_count), 0);
        chk("nominal_still_locked", int'(locked), 1);

        // A long line drops lock; the stream relocks after three more rises.
        clear_tally();
        frame(VT, VS, 5, HT + 1, HS, -1, -1);
        chk("long_line_hlen_pulses", n_hl, 1);
        chk("long_line_unlocked", int'(locked), 0);
        chk("long_line_count", int'(err_count), 1);
        good_frame(); good_frame();
        chk("relock_not_yet", int'(locked), 0);
        good_frame();
        chk("relock_after_3", int'(locked), 1);

        // A short hSync pulse, then a short frame, then a long vSync pulse.
        clear_tally(); c0 = int'(err_count);
        frame(VT, VS, 5, HT, HS - 1, -1, -1);
        chk("short_hsync_pulses", n_hsy, 1);
        chk("short_hsync_count", int'(err_count) - c0, 1);
        good_frame(); good_frame(); good_frame();
        clear_tally();
        frame(VT - 1, VS, -1, 0, 0, -1, -1);
        chk("short_frame_no_vlen_yet", n_vl, 0);
        good_frame();
        chk("short_frame_vlen", n_vl, 1);
        clear_tally();
        frame(VT, VS + 1, -1, 0, 0, -1, -1);
        chk("long_vsync_pulses", n_vsy, 1);
        good_frame();

        // Single-line anomaly table.
        for (int i = 0; i < 9; i++) begin
            clear_tally(); c0 = int'(err_count);
            frame(VT, VS, 5, vecs[i].len, vecs[i].hsw, vecs[i].br_at, -1);
            mask = {n_br > 0, n_vsy > 0, n_vl > 0, n_hsy > 0, n_hl > 0};
            chk($sformatf("vec%0d_mask", i), int'(mask), int'(vecs[i].exp_mask));
            chk($sformatf("vec%0d_count", i), int'(err_count) - c0, vecs[i].exp_cnt);
        end

        // A short line ends on a pixel that also has bright set during hSync: both flags in one clk.
        clear_tally(); c0 = int'(err_count);
        for (int l = 0; l < VT; l++) begin
            if (l == 5)      line(11, HS, 1'b0, -1, -1, 1'b1);
            else if (l == 6) line(HT, HS, 1'b0, 0, -1, 1'b1);
            else             line(HT, HS, l < VS, -1, -1, l >= 4 && l < VT - 1);
        end
        chk("same_clk_bright_hlen", n_both, 1);
        chk("same_clk_count", int'(err_count) - c0, 2);

        // Random stimulus with irregular strobe spacing, checked against the model.
        gap = -1;
        for (int f = 0; f < 15; f++) begin
            int nl, vsw, len, hsw, bra;
            nl  = ($urandom_range(0, 7) == 0) ? VT + int'($urandom_range(0, 2)) - 1 : VT;
            vsw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : VS;
            for (int l = 0; l < nl; l++) begin
                len = ($urandom_range(0, 19) == 0) ? HT + int'($urandom_range(0, 4)) - 2 : HT;
                hsw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 5)) : HS;
                bra = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, len - 1)) : -1;
                line(len, hsw, l < vsw, bra, -1, l >= 4 && l < nl - 1 && l >= vsw);
            end
        end
        gap = 3;

        // Strobe held off for 1000 clks mid-line while locked.
        good_frame(); good_frame(); good_frame();
        chk("pre_pause_locked", int'(locked), 1);
        frame(VT, VS, 5, HT, HS, -1, 7);
        chk("post_pause_locked", int'(locked), 1);

        // Saturation: 300 bright-during-vSync samples with no line starts.
        for (int i = 0; i < 300; i++) pix(1'b0, 1'b1, 1'b1);
        chk("count_saturated", int'(err_count), 255);
        // The first rise also reports the overlong line; three clean rises then lock.
        good_frame(); good_frame(); good_frame();
        chk("sat_relock_not_yet", int'(locked), 0);
        good_frame();
        chk("sat_relock", int'(locked), 1);
        chk("count_held_at_255", int'(err_count), 255);

        // Asynchronous reset mid-line.
        line(8, HS, 1'b0, -1, -1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_hc", int'(hc_rec), 0);
        chk("async_rst_vc", int'(vc_rec), 0);
        chk("async_rst_count", int'(err_count), 0);
        chk("async_rst_flags", int'({locked, frame_start, err_hlen, err_hsync, err_vlen, err_vsync, err_bright}), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        line(12, 0, 1'b0, -1, -1, 1'b0);
        good_frame(); good_frame();
        chk("post_rst_not_locked", int'(locked), 0);
        good_frame();
        chk("post_rst_locked", int'(locked), 1);
        chk("post_rst_count", int'(err_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
